hazard_scoreboard: RTL and testbench
====================================

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have parameter AW, default 5: register-address width.
REQ-002 SHALL have parameter BLOCKING_MD, default 0: 1 = any busy mult/div freezes PC/FD/DX; 0 = stall only on a dependency with the busy mult/div.
REQ-003 SHALL have parameter CNT_W, default 16: stall-counter width.
REQ-004 SHALL have port clock, input, 1: single clock; all state updates on the rising edge.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-high.
REQ-006 SHALL have ports rs_d, rt_d, rd_d, input, AW each: decode-stage source addresses.
REQ-007 SHALL have ports use_rs_d, use_rt_d, use_rd_d, input, 1 each: the matching source is actually read.
REQ-008 SHALL have port ld_x, input, 1: the execute-stage instruction is a load.
REQ-009 SHALL have port wd_x, input, AW: execute-stage destination.
REQ-010 SHALL have port md_issue, input, 1: a mult/div leaves DX this cycle (already qualified by ~stall_dx).
REQ-011 SHALL have port md_dest, input, AW: mult/div destination.
REQ-012 SHALL have port md_done, input, 1: mult/div result-ready pulse.
REQ-013 SHALL have port md_is_d, input, 1: the decode-stage instruction is a mult/div.
REQ-014 SHALL have ports stall_pc, stall_fd, stall_dx, nop_dx, output, 1 each: pipeline controls.
REQ-015 SHALL have port md_busy, output, 1: a mult/div is in flight.
REQ-016 SHALL have port md_err, output, 1: sticky protocol-error flag.
REQ-017 SHALL have port stall_cnt, output, CNT_W: count of stall cycles.

Function
REQ-018 SHALL treat address 0 as never hazardous for every comparison.
REQ-019 SHALL compute ld_hz = ld_x & (wd_x != 0) & (use_rs_d & rs_d == wd_x | use_rt_d & rt_d == wd_x | use_rd_d & rd_d == wd_x).
REQ-020 SHALL hold registers busy_q (1 bit) and dest_q (AW bits) as the in-flight mult/div tracker.
REQ-021 SHALL compute md_raw = busy_q & (dest_q != 0) & (a used decode source equals dest_q).
REQ-022 SHALL compute md_struct = busy_q & md_is_d & ~md_done.
REQ-023 SHALL, when BLOCKING_MD=1, compute md_hz = busy_q & ~md_done.
REQ-024 SHALL, when BLOCKING_MD=0, compute md_hz = (md_raw & ~md_done) | md_struct.
REQ-025 SHALL drive stall_pc = stall_fd = ld_hz | md_hz, combinationally.
REQ-026 SHALL, when BLOCKING_MD=1, drive stall_dx = md_hz and nop_dx = ld_hz & ~md_hz.
REQ-027 SHALL, when BLOCKING_MD=0, drive stall_dx = 0 and nop_dx = ld_hz | md_hz.
REQ-028 SHALL let a result complete in the same cycle it is consumed: md_done bypasses the stall in that cycle.
REQ-029 SHALL, next edge, clear busy_q when md_done & ~md_issue.
REQ-030 SHALL, next edge, set busy_q and load dest_q from md_dest when md_issue.
REQ-031 SHALL accept md_issue and md_done in the same cycle: the old entry retires, the new entry loads, and busy_q stays 1.
REQ-032 SHALL ignore md_done while busy_q=0.
REQ-033 SHALL set md_err, sticky until reset, on md_issue while busy_q & ~md_done, or on md_done while busy_q=0.
REQ-034 SHALL let the new issue overwrite the tracker when it sets md_err for an issue while busy.
REQ-035 SHALL drive md_busy = busy_q.
REQ-036 SHALL increment stall_cnt by 1 on each edge where stall_pc=1.
REQ-037 SHALL saturate stall_cnt at all-ones, with no wrap-around.

Reset
REQ-038 SHALL, on reset assertion and asynchronously, force busy_q=0, dest_q=0, md_err=0, stall_cnt=0.
REQ-039 SHALL, during reset, hold all stall/nop outputs at 0 regardless of inputs.
REQ-040 SHALL, on reset mid-operation, abandon any in-flight mult/div; the first md_done after reset then sets md_err.

Verification (AW=5, CNT_W=16 unless stated)
REQ-041 SHALL cover load-use: ld_x=1, wd_x=7, rs_d=7, use_rs_d=1 -> stall_pc=stall_fd=nop_dx=1, stall_dx=0; same with wd_x=0 -> all 0.
REQ-042 SHALL cover non-blocking RAW: md_issue with md_dest=9, then rt_d=9, use_rt_d=1 for 3 cycles -> stall+nop each cycle, stall_cnt=3; md_done on cycle 4 -> no stall, busy clears next edge.
REQ-043 SHALL cover BLOCKING_MD=1: issue, then unrelated sources -> stall_pc/fd/dx=1, nop_dx=0 until the md_done cycle, where all are 0.
REQ-044 SHALL cover back-to-back issue: md_done and md_issue (dest 4) together while busy with dest 9 -> busy stays 1, dest_q=4, md_err=0; a spurious md_done with busy=0 -> md_err=1 and it stays 1.
REQ-045 SHALL cover saturation: CNT_W=3, 10 stall cycles -> stall_cnt=7.
REQ-046 SHALL cover reset: assert reset while busy with stall_cnt=5 -> busy=0, stall_cnt=0, outputs 0 without a clock edge.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: load-use and mult/div hazard detection with an in-flight mult/div tracker.
// Ports:
//   clock, reset        - single clock, asynchronous active-high reset
//   rs_d/rt_d/rd_d      - decode-stage source addresses, qualified by use_rs_d/use_rt_d/use_rd_d
//   ld_x, wd_x          - execute-stage load flag and destination
//   md_issue, md_dest   - mult/div leaving DX this cycle and its destination
//   md_done             - mult/div result-ready pulse
//   md_is_d             - decode-stage instruction is a mult/div
//   stall_pc/fd/dx      - pipeline stall controls
//   nop_dx              - bubble insert into DX
//   md_busy             - mult/div in flight
//   md_err              - sticky protocol-error flag
//   stall_cnt           - saturating count of stall cycles
module hazard_scoreboard #(
    parameter int AW          = 5,
    parameter int BLOCKING_MD = 0,
    parameter int CNT_W       = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [AW-1:0]    rs_d,
    input  logic [AW-1:0]    rt_d,
    input  logic [AW-1:0]    rd_d,
    input  logic             use_rs_d,
    input  logic             use_rt_d,
    input  logic             use_rd_d,
    input  logic             ld_x,
    input  logic [AW-1:0]    wd_x,
    input  logic             md_issue,
    input  logic [AW-1:0]    md_dest,
    input  logic             md_done,
    input  logic             md_is_d,
    output logic             stall_pc,
    output logic             stall_fd,
    output logic             stall_dx,
    output logic             nop_dx,
    output logic             md_busy,
    output logic             md_err,
    output logic [CNT_W-1:0] stall_cnt
);
    logic             r_busy;
    logic [AW-1:0]    r_dest;
    logic             r_err;
    logic [CNT_W-1:0] r_cnt;
    logic             w_ld_hz;
    logic             w_md_raw;
    logic             w_md_struct;
    logic             w_md_hz;
    logic             w_stall;
    always_comb begin
        w_ld_hz     = ld_x && (wd_x != '0) &&
                      ((use_rs_d && rs_d == wd_x) || (use_rt_d && rt_d == wd_x) || (use_rd_d && rd_d == wd_x));
        w_md_raw    = r_busy && (r_dest != '0) &&
                      ((use_rs_d && rs_d == r_dest) || (use_rt_d && rt_d == r_dest) || (use_rd_d && rd_d == r_dest));
        w_md_struct = r_busy && md_is_d && !md_done;
        // md_done in the consuming cycle lets the dependent instruction proceed
        w_md_hz     = (BLOCKING_MD != 0) ? (r_busy && !md_done) : ((w_md_raw && !md_done) || w_md_struct);
        // reset forces every pipeline control low regardless of inputs
        w_stall     = !reset && (w_ld_hz || w_md_hz);
        stall_pc    = w_stall;
        stall_fd    = w_stall;
        stall_dx    = (BLOCKING_MD != 0) ? (!reset && w_md_hz) : 1'b0;
        nop_dx      = (BLOCKING_MD != 0) ? (!reset && w_ld_hz && !w_md_hz) : w_stall;
        md_busy     = r_busy;
        md_err      = r_err;
        stall_cnt   = r_cnt;
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_busy <= 1'b0;
            r_dest <= '0;
            r_err  <= 1'b0;
            r_cnt  <= '0;
        end else begin
            // an issue wins over a retire so back-to-back mult/div keeps the tracker busy
            if (md_issue) begin
                r_busy <= 1'b1;
                r_dest <= md_dest;
            end else if (md_done) begin
                r_busy <= 1'b0;
            end
            if ((md_issue && r_busy && !md_done) || (md_done && !r_busy))
                r_err <= 1'b1;
            if (w_stall && r_cnt != '1)
                r_cnt <= r_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed checks of non-blocking, blocking and narrow-counter scoreboards.
module tb_hazard_scoreboard;
    logic       clock, reset;
    logic [4:0] rs_d, rt_d, rd_d, wd_x, md_dest;
    logic       use_rs_d, use_rt_d, use_rd_d, ld_x, md_issue, md_done, md_is_d;
    logic        a_pc, a_fd, a_dx, a_nop, a_busy, a_err;
    logic [15:0] a_cnt;
    logic        b_pc, b_fd, b_dx, b_nop, b_busy, b_err;
    logic [15:0] b_cnt;
    logic        c_pc, c_fd, c_dx, c_nop, c_busy, c_err;
    logic [2:0]  c_cnt;
    int checks = 0;
    int errors = 0;

    hazard_scoreboard #(.AW(5), .BLOCKING_MD(0), .CNT_W(16)) u_a (
        .clock(clock), .reset(reset), .rs_d(rs_d), .rt_d(rt_d), .rd_d(rd_d),
        .use_rs_d(use_rs_d), .use_rt_d(use_rt_d), .use_rd_d(use_rd_d),
        .ld_x(ld_x), .wd_x(wd_x), .md_issue(md_issue), .md_dest(md_dest),
        .md_done(md_done), .md_is_d(md_is_d),
        .stall_pc(a_pc), .stall_fd(a_fd), .stall_dx(a_dx), .nop_dx(a_nop),
        .md_busy(a_busy), .md_err(a_err), .stall_cnt(a_cnt));
    hazard_scoreboard #(.AW(5), .BLOCKING_MD(1), .CNT_W(16)) u_b (
        .clock(clock), .reset(reset), .rs_d(rs_d), .rt_d(rt_d), .rd_d(rd_d),
        .use_rs_d(use_rs_d), .use_rt_d(use_rt_d), .use_rd_d(use_rd_d),
        .ld_x(ld_x), .wd_x(wd_x), .md_issue(md_issue), .md_dest(md_dest),
        .md_done(md_done), .md_is_d(md_is_d),
        .stall_pc(b_pc), .stall_fd(b_fd), .stall_dx(b_dx), .nop_dx(b_nop),
        .md_busy(b_busy), .md_err(b_err), .stall_cnt(b_cnt));
    hazard_scoreboard #(.AW(5), .BLOCKING_MD(0), .CNT_W(3)) u_c (
        .clock(clock), .reset(reset), .rs_d(rs_d), .rt_d(rt_d), .rd_d(rd_d),
        .use_rs_d(use_rs_d), .use_rt_d(use_rt_d), .use_rd_d(use_rd_d),
        .ld_x(ld_x), .wd_x(wd_x), .md_issue(md_issue), .md_dest(md_dest),
        .md_done(md_done), .md_is_d(md_is_d),
        .stall_pc(c_pc), .stall_fd(c_fd), .stall_dx(c_dx), .nop_dx(c_nop),
        .md_busy(c_busy), .md_err(c_err), .stall_cnt(c_cnt));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clr();
        rs_d = 0; rt_d = 0; rd_d = 0; wd_x = 0; md_dest = 0;
        use_rs_d = 0; use_rt_d = 0; use_rd_d = 0;
        ld_x = 0; md_issue = 0; md_done = 0; md_is_d = 0;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        clr();
        #3;
        chk("rst_busy", a_busy, 0);
        chk("rst_cnt", a_cnt, 0);
        chk("rst_err", a_err, 0);
        ld_x = 1; wd_x = 7; rs_d = 7; use_rs_d = 1;
        #1;
        chk("rst_hold_pc", a_pc, 0);
        chk("rst_hold_nop", a_nop, 0);
        clr();
        tick();
        reset = 1'b0;
        // load-use
        ld_x = 1; wd_x = 7; rs_d = 7; use_rs_d = 1;
        #1;
        chk("lu_pc", a_pc, 1);
        chk("lu_fd", a_fd, 1);
        chk("lu_nop", a_nop, 1);
        chk("lu_dx", a_dx, 0);
        chk("lu_b_nop", b_nop, 1);
        chk("lu_b_dx", b_dx, 0);
        wd_x = 0;
        #1;
        chk("lu_wd0_pc", a_pc, 0);
        chk("lu_wd0_nop", a_nop, 0);
        rs_d = 0;
        #1;
        chk("lu_zero_pc", a_pc, 0);
        rs_d = 7; use_rs_d = 0; wd_x = 12; rd_d = 12; use_rd_d = 1;
        #1;
        chk("lu_rd_pc", a_pc, 1);
        use_rd_d = 0;
        #1;
        chk("lu_rd_unused", a_pc, 0);
        clr();
        tick();
        // non-blocking RAW and blocking freeze
        md_issue = 1; md_dest = 9;
        #1;
        chk("iss_pc", a_pc, 0);
        tick();
        md_issue = 0; md_dest = 0;
        #1;
        chk("iss_busy", a_busy, 1);
        chk("iss_err", a_err, 0);
        chk("unrel_a_pc", a_pc, 0);
        chk("unrel_b_pc", b_pc, 1);
        chk("unrel_b_dx", b_dx, 1);
        chk("unrel_b_nop", b_nop, 0);
        md_is_d = 1;
        #1;
        chk("struct_pc", a_pc, 1);
        chk("struct_nop", a_nop, 1);
        md_is_d = 0; rt_d = 9; use_rt_d = 1;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("raw_pc", a_pc, 1);
            chk("raw_nop", a_nop, 1);
            chk("raw_dx", a_dx, 0);
            chk("raw_b_dx", b_dx, 1);
            tick();
        end
        chk("raw_cnt", a_cnt, 3);
        chk("raw_b_cnt", b_cnt, 3);
        md_done = 1;
        #1;
        chk("done_pc", a_pc, 0);
        chk("done_nop", a_nop, 0);
        chk("done_b_pc", b_pc, 0);
        chk("done_b_dx", b_dx, 0);
        chk("done_busy_held", a_busy, 1);
        tick();
        clr();
        #1;
        chk("done_busy_clr", a_busy, 0);
        chk("done_b_busy_clr", b_busy, 0);
        chk("done_cnt", a_cnt, 3);
        chk("done_err", a_err, 0);
        // back-to-back issue
        md_issue = 1; md_dest = 9;
        tick();
        md_done = 1; md_dest = 4;
        #1;
        chk("b2b_pc", a_pc, 0);
        tick();
        clr();
        #1;
        chk("b2b_busy", a_busy, 1);
        chk("b2b_err", a_err, 0);
        rs_d = 4; use_rs_d = 1;
        #1;
        chk("b2b_dest4", a_pc, 1);
        rs_d = 9;
        #1;
        chk("b2b_dest9", a_pc, 0);
        clr();
        md_done = 1;
        tick();
        md_done = 0;
        #1;
        chk("b2b_retire_busy", a_busy, 0);
        chk("b2b_retire_err", a_err, 0);
        md_done = 1;
        tick();
        md_done = 0;
        #1;
        chk("spur_err", a_err, 1);
        tick();
        chk("spur_err_sticky", a_err, 1);
        chk("spur_cnt", a_cnt, 3);
        // saturation of the 3-bit counter
        ld_x = 1; wd_x = 7; rs_d = 7; use_rs_d = 1;
        for (int i = 0; i < 4; i++) tick();
        chk("sat_c_7", c_cnt, 7);
        for (int i = 0; i < 6; i++) tick();
        chk("sat_c_hold", c_cnt, 7);
        chk("sat_a_cnt", a_cnt, 13);
        clr();
        // reset mid-operation
        md_issue = 1; md_dest = 2;
        tick();
        md_issue = 0; md_dest = 0;
        ld_x = 1; wd_x = 7; rs_d = 7; use_rs_d = 1;
        #1;
        chk("pre_busy", a_busy, 1);
        chk("pre_a_nop", a_nop, 1);
        chk("pre_b_nop", b_nop, 0);
        chk("pre_b_dx", b_dx, 1);
        reset = 1'b1;
        #1;
        chk("mid_busy", a_busy, 0);
        chk("mid_cnt", a_cnt, 0);
        chk("mid_err", a_err, 0);
        chk("mid_pc", a_pc, 0);
        chk("mid_nop", a_nop, 0);
        chk("mid_b_dx", b_dx, 0);
        chk("mid_b_busy", b_busy, 0);
        #1;
        reset = 1'b0;
        clr();
        md_done = 1;
        tick();
        md_done = 0;
        #1;
        chk("post_rst_err", a_err, 1);
        chk("post_rst_busy", a_busy, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
